if_id_fetch_queue: RTL and testbench
====================================

Name: if_id_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry FIFO of {addedPC, inst} pairs sits between the fetch stage and the decode stage.
- IF can keep fetching while ID is stalled by the hazard unit; a jump or branch flushes every queued entry in one cycle.
- ID sees a NOP (all-zero) bubble whenever no valid entry is presented.

Parameters:
- PC_W, 32, width of addedPC field.
- INST_W, 32, width of instruction field.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden).

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  asynchronous, active-low reset.
- enq_valid_i  input  1  IF presents a fetched instruction this cycle.
- addedPC_i  input  PC_W  PC+4 of fetched instruction.
- inst_i  input  INST_W  fetched instruction word.
- enq_ready_o  output  1  queue can accept an entry this cycle.
- stall_i  input  1  hazard stall from ID; head entry must be held.
- jump_i  input  1  jump resolved; flush request.
- branch_i  input  1  taken branch resolved; flush request.
- deq_valid_o  output  1  addedPC_o/inst_o carry a valid entry.
- addedPC_o  output  PC_W  head entry PC+4; zero when deq_valid_o=0.
- inst_o  output  INST_W  head entry instruction; zero (NOP) when deq_valid_o=0.
- count_o  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_i=0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - deq_valid_o=0, addedPC_o=0, inst_o=0, enq_ready_o=1, count_o=0.
  - Storage array contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately; no partial enqueue survives.
- flush = jump_i | branch_i (combinational OR, internal).
- enq_fire = enq_valid_i & enq_ready_o & ~flush.
- deq_fire = deq_valid_o & ~stall_i & ~flush.
- enq_ready_o = (count != DEPTH). It depends only on registered count and does not look ahead at deq_fire.
- deq_valid_o = (count != 0). addedPC_o/inst_o are read combinationally from storage[rd_ptr] and gated to zero when count=0.
- On posedge with flush=1:
  - wr_ptr <= 0, rd_ptr <= 0, count <= 0.
  - Any same-cycle enqueue is dropped.
  - Flush has priority over stall_i and enq_valid_i.
- On posedge without flush:
  - enq_fire: storage[wr_ptr] <= {addedPC_i, inst_i}; wr_ptr <= wr_ptr+1 mod DEPTH.
  - deq_fire: rd_ptr <= rd_ptr+1 mod DEPTH.
  - count <= count + enq_fire - deq_fire. Simultaneous enq and deq leaves count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally; no explicit compare against DEPTH-1.
- Latency: an entry enqueued at edge N is visible on outputs after edge N when the queue was empty. There is no same-cycle bypass from input to output.
- stall_i=1: head entry and rd_ptr held; enqueues continue until full.
- Full (count=DEPTH): enq_ready_o=0. Enqueue is refused even if deq_fire occurs the same cycle, and IF must hold.
- Empty (count=0): outputs zero. stall_i has no effect.
- Ordering: strict FIFO; no entry is duplicated or skipped across pointer wrap.
- Invariants (checked by assertions):
  - count <= DEPTH.
  - (wr_ptr - rd_ptr) mod DEPTH == count mod DEPTH.
  - deq_valid_o=0 implies addedPC_o=0 and inst_o=0.

Test Plan:
- Reset then idle: rst_i low 2 cycles, release → deq_valid_o=0, inst_o=0, addedPC_o=0, enq_ready_o=1, count_o=0.
- Streaming: enqueue {0x4,0x8C010000},{0x8,0x00221820},{0xC,0xAC030004} on consecutive cycles, no stall → outputs appear one cycle after each enqueue in order; count_o stays ≤1.
- Stall fill: stall_i=1, enqueue 5 entries with DEPTH=4 → count_o reaches 4, enq_ready_o=0 on the 5th cycle, 5th entry not stored. Release stall → 4 entries drain in order, count_o 4→0.
- Flush priority: 3 entries queued, branch_i=1 with enq_valid_i=1 and stall_i=1 in the same cycle → next cycle count_o=0, inst_o=0, new entry dropped. The following enqueue lands and appears normally.
- Wrap-around: 10 enqueue/dequeue pairs with intermittent 2-cycle stalls, DEPTH=4 → output sequence equals input sequence across two pointer wraps; count_o never exceeds 4.
- Async reset mid-run: assert rst_i between clock edges with count_o=3 → outputs zero immediately, before the next posedge; after release the queue accepts entries from wr_ptr=0.

Source files
------------

// File: rtl/if_id_fetch_queue.sv
// Fetch queue between IF and ID: a DEPTH-entry FIFO of {addedPC, inst} pairs.
// ID sees an all-zero bubble when empty; a jump or taken branch empties the queue in one cycle.
module if_id_fetch_queue #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enq_valid_i,
   input  logic [PC_W-1:0]   addedPC_i,
   input  logic [INST_W-1:0] inst_i,
   output logic              enq_ready_o,
   input  logic              stall_i,
   input  logic              jump_i,
   input  logic              branch_i,
   output logic              deq_valid_o,
   output logic [PC_W-1:0]   addedPC_o,
   output logic [INST_W-1:0] inst_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = PC_W + INST_W;

   logic [ENT_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             flush_s;
   logic             enq_fire_s;
   logic             deq_fire_s;
   logic [ENT_W-1:0] head_s;

   assign flush_s     = jump_i | branch_i;
   assign enq_ready_o = (count_r != CNT_W'(DEPTH));
   assign deq_valid_o = (count_r != {CNT_W{1'b0}});
   assign enq_fire_s  = enq_valid_i & enq_ready_o & ~flush_s;
   assign deq_fire_s  = deq_valid_o & ~stall_i & ~flush_s;
   assign head_s      = mem_r[rd_ptr_r];
   assign count_o     = count_r;

   // Pointer and occupancy state; flush outranks stall and enqueue.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush_s) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (enq_fire_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (deq_fire_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(enq_fire_s) - CNT_W'(deq_fire_s);
      end
   end

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk_i) begin
      if (enq_fire_s) begin
         mem_r[wr_ptr_r] <= {addedPC_i, inst_i};
      end
   end

   // Head presentation, forced to a NOP bubble when nothing is queued.
   always_comb begin
      addedPC_o = {PC_W{1'b0}};
      inst_o    = {INST_W{1'b0}};
      if (deq_valid_o) begin
         addedPC_o = head_s[ENT_W-1:INST_W];
         inst_o    = head_s[INST_W-1:0];
      end else begin
         addedPC_o = {PC_W{1'b0}};
         inst_o    = {INST_W{1'b0}};
      end
   end

   if_id_fetch_queue_chk #(
      .PC_W   (PC_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH)
   ) u_chk (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_ptr      (wr_ptr_r),
      .rd_ptr      (rd_ptr_r),
      .count       (count_r),
      .deq_valid   (deq_valid_o),
      .addedPC     (addedPC_o),
      .inst        (inst_o)
   );

endmodule

// Structural invariants of the fetch queue.
module if_id_fetch_queue_chk #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input logic              clk_i,
   input logic              rst_i,
   input logic [PTR_W-1:0]  wr_ptr,
   input logic [PTR_W-1:0]  rd_ptr,
   input logic [CNT_W-1:0]  count,
   input logic              deq_valid,
   input logic [PC_W-1:0]   addedPC,
   input logic [INST_W-1:0] inst
);

   logic [PTR_W-1:0] diff_s;
   assign diff_s = wr_ptr - rd_ptr;

   // Sampled on every active edge while out of reset.
   always @(posedge clk_i) begin
      if (rst_i) begin
         assert (count <= CNT_W'(DEPTH))
            else $error("fetch queue occupancy above DEPTH");
         assert (diff_s == count[PTR_W-1:0])
            else $error("fetch queue pointers disagree with occupancy");
         assert (deq_valid || (addedPC == {PC_W{1'b0}} && inst == {INST_W{1'b0}}))
            else $error("fetch queue bubble not zero");
      end
   end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Scoreboard bench for if_id_fetch_queue: a reference queue models the FIFO and
// every cycle the DUT outputs are compared with it between clock edges.
module tb_if_id_fetch_queue;

   localparam int PC_W   = 32;
   localparam int INST_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              enq_valid_i;
   logic [PC_W-1:0]   addedPC_i;
   logic [INST_W-1:0] inst_i;
   logic              enq_ready_o;
   logic              stall_i;
   logic              jump_i;
   logic              branch_i;
   logic              deq_valid_o;
   logic [PC_W-1:0]   addedPC_o;
   logic [INST_W-1:0] inst_o;
   logic [CNT_W-1:0]  count_o;

   logic [63:0] sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   if_id_fetch_queue #(
      .PC_W   (PC_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enq_valid_i (enq_valid_i),
      .addedPC_i   (addedPC_i),
      .inst_i      (inst_i),
      .enq_ready_o (enq_ready_o),
      .stall_i     (stall_i),
      .jump_i      (jump_i),
      .branch_i    (branch_i),
      .deq_valid_o (deq_valid_o),
      .addedPC_o   (addedPC_o),
      .inst_o      (inst_o),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Compare outputs against the model, then advance the model by this cycle's inputs.
   task automatic step(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic jp, input logic br, output logic acc);
      logic flush, enq, deq;
      @(negedge clk_i);
      enq_valid_i = ev;
      addedPC_i   = pc;
      inst_i      = ins;
      stall_i     = st;
      jump_i      = jp;
      branch_i    = br;
      #1;
      check_eq("count", 64'(count_o), 64'(sb_q.size()));
      check_eq("ready", 64'(enq_ready_o), 64'(sb_q.size() != DEPTH));
      check_eq("valid", 64'(deq_valid_o), 64'(sb_q.size() != 0));
      flush = jp | br;
      enq   = ev & (sb_q.size() != DEPTH) & ~flush;
      deq   = (sb_q.size() != 0) & ~st & ~flush;
      if (sb_q.size() != 0) begin
         check_eq("head", {addedPC_o, inst_o}, sb_q[0]);
      end else begin
         check_eq("bubble", {addedPC_o, inst_o}, 64'd0);
      end
      if (flush) begin
         sb_q.delete();
      end else begin
         if (deq) void'(sb_q.pop_front());
         if (enq) sb_q.push_back({pc, ins});
      end
      acc = enq;
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, a);
   endtask

   initial begin
      logic acc;
      int   sent;
      rst_i       = 1'b0;
      enq_valid_i = 1'b0;
      addedPC_i   = '0;
      inst_i      = '0;
      stall_i     = 1'b0;
      jump_i      = 1'b0;
      branch_i    = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check_eq("rst_valid", 64'(deq_valid_o), 64'd0);
      check_eq("rst_inst", 64'(inst_o), 64'd0);
      check_eq("rst_pc", 64'(addedPC_o), 64'd0);
      check_eq("rst_ready", 64'(enq_ready_o), 64'd1);
      check_eq("rst_count", 64'(count_o), 64'd0);
      idle(1);

      // Streaming without stall
      step(1'b1, 32'h4, 32'h8C010000, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h8, 32'h00221820, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'hC, 32'hAC030004, 1'b0, 1'b0, 1'b0, acc);
      idle(2);

      // Stall fill: fifth enqueue refused, then drain
      for (int i = 0; i < 5; i++) step(1'b1, 32'h40 + 32'(i * 4), 32'hA000 + 32'(i), 1'b1, 1'b0, 1'b0, acc);
      check_eq("full_refused", 64'(acc), 64'd0);
      idle(6);

      // Flush priority over stall and enqueue
      for (int i = 0; i < 3; i++) step(1'b1, 32'h80 + 32'(i * 4), 32'hB000 + 32'(i), 1'b1, 1'b0, 1'b0, acc);
      step(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b1, acc);
      step(1'b1, 32'h200, 32'h12345678, 1'b0, 1'b0, 1'b0, acc);
      idle(2);
      for (int i = 0; i < 2; i++) step(1'b1, 32'h90 + 32'(i * 4), 32'hC000 + 32'(i), 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);
      idle(2);

      // Wrap-around with intermittent 2-cycle stalls
      sent = 0;
      for (int cyc = 0; cyc < 200 && (sent < 10 || sb_q.size() != 0); cyc++) begin
         step(sent < 10, 32'h100 + 32'(sent * 4), $urandom, (cyc % 5) >= 3, 1'b0, 1'b0, acc);
         if (acc) sent++;
      end
      check_eq("wrap_sent", 64'(sent), 64'd10);
      check_eq("wrap_left", 64'(sb_q.size()), 64'd0);

      // Asynchronous reset between edges with three entries queued
      for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i * 4), 32'hD000 + 32'(i), 1'b1, 1'b0, 1'b0, acc);
      @(negedge clk_i);
      enq_valid_i = 1'b0;
      stall_i     = 1'b0;
      #2 rst_i = 1'b0;
      #1;
      check_eq("arst_count", 64'(count_o), 64'd0);
      check_eq("arst_valid", 64'(deq_valid_o), 64'd0);
      check_eq("arst_out", {addedPC_o, inst_o}, 64'd0);
      sb_q.delete();
      @(negedge clk_i);
      rst_i = 1'b1;
      step(1'b1, 32'h400, 32'hE0E0E0E0, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h404, 32'hE1E1E1E1, 1'b0, 1'b0, 1'b0, acc);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
